// File: rtl/wishbone_ram_slave.sv
// Pipelined Wishbone B4 slave in front of a byte-lane block RAM, fixed response latency.
// Optional macro WISHBONE_RAM_SLAVE_ERR_EN adds ERR_O for addresses at or above MEM_DEPTH.
module wishbone_ram_slave #(
    parameter int AW              = 8,
    parameter int MEM_DEPTH       = 256,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
`ifdef WISHBONE_RAM_SLAVE_ERR_EN
    output logic        ERR_O,
`endif
    output logic        STALL_O
);

    localparam int CW = 3;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic [LATENCY-1:0] vld_reg;
    logic [LATENCY-1:0] rd_reg;
    logic [LATENCY-1:0] bad_reg;
    logic [31:0]        tail_reg [LATENCY];
    logic [31:0]        ram_q;
    logic [31:0]        final_data;
    logic [31:0]        dat_reg;
    logic               ack_reg;
    logic [AW-1:0]      idx;
    logic               addr_bad;
    logic               accept;
    logic               wr_go;
    logic               rd_go;
    logic               retire;

    assign idx = ADR_I[AW-1:0];

`ifdef WISHBONE_RAM_SLAVE_ERR_EN
    logic err_reg;

    assign addr_bad = (ADR_I >= 32'(MEM_DEPTH));
    assign ERR_O    = err_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N || !CYC_I) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= retire & bad_reg[LATENCY-1];
        end
    end
`else
    // Upper address bits only matter for range checking; without it they fold away.
    logic unused_adr_hi;

    assign addr_bad      = 1'b0;
    assign unused_adr_hi = ^ADR_I[31:AW];
`endif

    // Stall depends on the registered count only, never on the bus inputs.
    assign STALL_O = (count_reg >= MAX_CNT);
    assign accept  = RST_N & CYC_I & STB_I & ~STALL_O;
    assign wr_go   = accept & WE_I & ~addr_bad;
    assign rd_go   = accept & ~WE_I & ~addr_bad;
    assign retire  = vld_reg[LATENCY-1];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [2**AW];
            logic [7:0] q_reg;

            always_ff @(posedge CLK) begin
                if (wr_go && SEL_I[gi]) begin
                    mem[idx] <= DAT_I[gi*8 +: 8];
                end
                if (rd_go) begin
                    q_reg <= mem[idx];
                end
            end

            assign ram_q[gi*8 +: 8] = q_reg;
        end

        // The RAM output register is stage 0's data; later stages shift it along.
        if (LATENCY == 1) begin : g_lat1
            assign final_data = ram_q;
        end else begin : g_latn
            assign final_data = tail_reg[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        rd_reg[0]   <= rd_go;
        bad_reg[0]  <= accept & addr_bad;
        tail_reg[0] <= ram_q;
        for (int i = 1; i < LATENCY; i++) begin
            rd_reg[i]   <= rd_reg[i-1];
            bad_reg[i]  <= bad_reg[i-1];
            tail_reg[i] <= tail_reg[i-1];
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({accept, retire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Dropping CYC_I aborts everything in flight exactly like a reset of the pipeline.
    always_ff @(posedge CLK) begin
        if (!RST_N || !CYC_I) begin
            vld_reg   <= '0;
            count_reg <= '0;
            ack_reg   <= 1'b0;
            dat_reg   <= '0;
        end else begin
            vld_reg[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
            count_reg <= count_next;
            ack_reg   <= retire & ~bad_reg[LATENCY-1];
            dat_reg   <= (retire && rd_reg[LATENCY-1]) ? final_data : 32'h0;
        end
    end

    assign ACK_O = ack_reg;
    assign DAT_O = dat_reg;

endmodule
